// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, reads combinational instruction memory, and registers {pc, word} into IF/ID.
// Latency 1 cycle PC->if_pc; IF/ID holds while if_valid && !id_ready; a misaligned redirect halts fetch until reset.
module instruction_fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  output logic [63:0] Inst_Address,
  input  logic [31:0] Instruction,
  input  logic        branch_taken,
  input  logic [63:0] branch_target,
  input  logic        id_ready,
  output logic        if_valid,
  output logic [63:0] if_pc,
  output logic [31:0] if_instruction,
  output logic        fetch_error,
  output logic [31:0] fetch_count
);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [63:0] pc;
  logic [63:0] pc_next;
  logic        valid_next;
  logic [63:0] if_pc_next;
  logic [31:0] instr_next;
  logic        error_next;
  logic [31:0] count_next;

  logic        can_load;
  logic        transfer;
  logic        misaligned;

  assign Inst_Address = pc;
  assign can_load     = !if_valid || id_ready;
  assign transfer     = if_valid && id_ready;
  assign misaligned   = branch_target[1:0] != 2'b00;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= RUN;
      pc             <= RESET_PC;
      if_valid       <= 1'b0;
      if_pc          <= 64'h0;
      if_instruction <= NOP_WORD;
      fetch_error    <= 1'b0;
      fetch_count    <= 32'h0;
    end else begin
      state          <= state_next;
      pc             <= pc_next;
      if_valid       <= valid_next;
      if_pc          <= if_pc_next;
      if_instruction <= instr_next;
      fetch_error    <= error_next;
      fetch_count    <= count_next;
    end
  end

  always_comb begin
    state_next = state;
    pc_next    = pc;
    valid_next = if_valid;
    if_pc_next = if_pc;
    instr_next = if_instruction;
    error_next = fetch_error;
    count_next = fetch_count;

    case (state)
      RUN: begin
        // A word leaving IF/ID in the same cycle as a redirect belongs to the squashed path.
        if (transfer && !branch_taken) begin
          count_next = fetch_count + 32'd1;
        end

        if (branch_taken && misaligned) begin
          state_next = HALT;
          error_next = 1'b1;
          valid_next = 1'b0;
          instr_next = NOP_WORD;
        end else if (branch_taken) begin
          valid_next = 1'b0;
          instr_next = NOP_WORD;
          pc_next    = branch_target;
        end else if (can_load) begin
          if_pc_next = pc;
          instr_next = Instruction;
          valid_next = 1'b1;
          pc_next    = pc + 64'd4;
        end
      end

      HALT: begin
        valid_next = 1'b0;
      end

      default: begin
        state_next = RUN;
      end
    endcase
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed test-plan scenarios plus randomized traffic against a behavioural model.
module tb_instruction_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic [63:0] Inst_Address;
  logic [31:0] Instruction;
  logic        branch_taken;
  logic [63:0] branch_target;
  logic        id_ready;
  logic        if_valid;
  logic [63:0] if_pc;
  logic [31:0] if_instruction;
  logic        fetch_error;
  logic [31:0] fetch_count;

  int checks = 0;
  int errors = 0;

  instruction_fetch_unit dut (
    .clk(clk),
    .reset(reset),
    .Inst_Address(Inst_Address),
    .Instruction(Instruction),
    .branch_taken(branch_taken),
    .branch_target(branch_target),
    .id_ready(id_ready),
    .if_valid(if_valid),
    .if_pc(if_pc),
    .if_instruction(if_instruction),
    .fetch_error(fetch_error),
    .fetch_count(fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (a == 64'h0) return 32'h0070_0093;
    if (a == 64'h4) return 32'h0011_0133;
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_0000;
  endfunction

  assign Instruction = mem_word(Inst_Address);

  // Behavioural model: architectural fetch state plus the list of PCs decode has accepted.
  logic [63:0] m_pc;
  logic        m_valid;
  logic [63:0] m_ipc;
  logic [31:0] m_instr;
  logic        m_halt;
  logic [63:0] accepted[$];

  function automatic void model_reset();
    m_pc    = 64'h0;
    m_valid = 1'b0;
    m_ipc   = 64'h0;
    m_instr = NOP;
    m_halt  = 1'b0;
    accepted.delete();
  endfunction

  initial model_reset();

  always @(posedge clk) begin
    if (reset) begin
      model_reset();
    end else if (!m_halt) begin
      if (m_valid && id_ready && !branch_taken) accepted.push_back(m_ipc);
      if (branch_taken) begin
        m_valid = 1'b0;
        m_instr = NOP;
        if (branch_target % 4 != 0) m_halt = 1'b1;
        else                        m_pc = branch_target;
      end else if (!m_valid || id_ready) begin
        m_ipc   = m_pc;
        m_instr = mem_word(m_pc);
        m_valid = 1'b1;
        m_pc    = m_pc + 64'd4;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("cmp_addr",  Inst_Address, m_pc);
    chk("cmp_valid", {63'h0, if_valid}, {63'h0, m_valid});
    chk("cmp_err",   {63'h0, fetch_error}, {63'h0, m_halt});
    chk("cmp_count", {32'h0, fetch_count}, 64'(accepted.size()));
    chk("cmp_instr", {32'h0, if_instruction}, {32'h0, m_instr});
    if (m_valid) chk("cmp_pc", if_pc, m_ipc);
  end

  // Called at posedge+1; applies inputs for the coming edge and returns at the next posedge+1.
  task automatic cyc(input logic bt, input logic [63:0] tgt, input logic rdy);
    branch_taken  = bt;
    branch_target = tgt;
    id_ready      = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_valid"}, {63'h0, if_valid}, 64'h0);
    chk({tag, "_addr"},  Inst_Address, 64'h0);
    chk({tag, "_err"},   {63'h0, fetch_error}, 64'h0);
    chk({tag, "_count"}, {32'h0, fetch_count}, 64'h0);
    chk({tag, "_instr"}, {32'h0, if_instruction}, {32'h0, NOP});
  endtask

  // Asserts reset between edges (posedge+3) and releases it at posedge+1 one edge later.
  task automatic do_reset(input bit check_now);
    branch_taken = 1'b0;
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    if (check_now) check_reset_values("async_rst");
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset         = 1'b1;
    branch_taken  = 1'b0;
    branch_target = 64'h0;
    id_ready      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    chk("reset_if_pc", if_pc, 64'h0);
    reset = 1'b0;

    // Sequential fetch
    cyc(1'b0, 64'h0, 1'b1);
    chk("seq0_pc", if_pc, 64'h0);
    chk("seq0_instr", {32'h0, if_instruction}, 64'h0070_0093);
    chk("seq0_valid", {63'h0, if_valid}, 64'h1);
    chk("seq0_addr", Inst_Address, 64'h4);

    // Stall for 3 cycles
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 64'h0, 1'b0);
      chk("stall_pc", if_pc, 64'h0);
      chk("stall_instr", {32'h0, if_instruction}, 64'h0070_0093);
      chk("stall_addr", Inst_Address, 64'h4);
      chk("stall_count", {32'h0, fetch_count}, 64'h0);
    end
    cyc(1'b0, 64'h0, 1'b1);
    chk("seq1_pc", if_pc, 64'h4);
    chk("seq1_instr", {32'h0, if_instruction}, 64'h0011_0133);
    chk("seq1_count", {32'h0, fetch_count}, 64'h1);
    cyc(1'b0, 64'h0, 1'b1);
    chk("seq2_count", {32'h0, fetch_count}, 64'h2);
    chk("seq2_pc", if_pc, 64'h8);

    // Redirect coinciding with a transfer
    cyc(1'b1, 64'h40, 1'b1);
    chk("redir_valid", {63'h0, if_valid}, 64'h0);
    chk("redir_addr", Inst_Address, 64'h40);
    chk("redir_count", {32'h0, fetch_count}, 64'h2);
    cyc(1'b0, 64'h0, 1'b1);
    chk("redir_pc", if_pc, 64'h40);
    chk("redir_valid2", {63'h0, if_valid}, 64'h1);
    chk("redir_count2", {32'h0, fetch_count}, 64'h2);

    // PC wrap
    cyc(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1);
    chk("wrap_addr0", Inst_Address, 64'hFFFF_FFFF_FFFF_FFFC);
    cyc(1'b0, 64'h0, 1'b1);
    chk("wrap_addr1", Inst_Address, 64'h0);
    chk("wrap_pc", if_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_err", {63'h0, fetch_error}, 64'h0);

    // Misaligned redirect halts; later redirect ignored
    cyc(1'b1, 64'h42, 1'b1);
    chk("mis_err", {63'h0, fetch_error}, 64'h1);
    chk("mis_valid", {63'h0, if_valid}, 64'h0);
    chk("mis_addr", Inst_Address, 64'h0);
    cyc(1'b1, 64'h80, 1'b1);
    chk("halt_addr", Inst_Address, 64'h0);
    chk("halt_valid", {63'h0, if_valid}, 64'h0);
    cyc(1'b0, 64'h0, 1'b1);
    chk("halt_addr2", Inst_Address, 64'h0);

    // Async reset mid-stream with a live IF/ID word
    do_reset(1'b0);
    cyc(1'b0, 64'h0, 1'b1);
    cyc(1'b0, 64'h0, 1'b1);
    chk("pre_rst_valid", {63'h0, if_valid}, 64'h1);
    do_reset(1'b1);

    // Randomized traffic in segments separated by resets
    for (int seg = 0; seg < 8; seg++) begin
      for (int i = 0; i < 300; i++) begin
        int          r;
        logic        bt;
        logic [63:0] tgt;
        r   = $urandom_range(0, 99);
        bt  = ($urandom_range(0, 7) == 0);
        if (r < 2)      tgt = {52'h0, 10'($urandom_range(0, 1023)), 2'($urandom_range(1, 3))};
        else if (r < 6) tgt = (r < 4) ? 64'hFFFF_FFFF_FFFF_FFF8 : 64'hFFFF_FFFF_FFFF_FFFC;
        else            tgt = {54'h0, 8'($urandom_range(0, 255)), 2'b00};
        cyc(bt, tgt, ($urandom_range(0, 3) != 0));
      end
      do_reset(1'b0);
    end

    cyc(1'b0, 64'h0, 1'b1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
